median_window_feeder: RTL and testbench
=======================================

Name: median_window_feeder

Overview:
Producer/consumer companion to the 3-input median filter datapath.
- Accepts a serial sample stream and forms a sliding 3-sample window.
- Drives the window onto the three median word inputs.
- Collects each median result after a fixed latency and emits it on a ready/valid output stream.
- Frames the run with start/done and a fixed sample count per frame.

Parameters:
WIDTH, 32, sample and median word width
COUNT, 8533, samples per frame (must be >= 3); medians emitted per frame = COUNT-2
MED_LAT, 2, cycles from window presentation to median valid on med_in (>= 1)
FIFO_DEPTH, 4, output buffer entries (must be >= MED_LAT+1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the last median of the frame has been accepted downstream
s_valid  input  1  input sample valid
s_ready  output  1  feeder accepts sample this cycle
s_data  input  WIDTH  input sample
win0  output  WIDTH  oldest window sample (to median word0)
win1  output  WIDTH  middle window sample (to median word1)
win2  output  WIDTH  newest window sample (to median word2)
med_in  input  WIDTH  median result from filter, valid MED_LAT cycles after window update
m_valid  output  1  output median valid
m_ready  input  1  downstream accepts median
m_data  output  WIDTH  output median
out_count  output  32  medians accepted downstream in current frame

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; busy, done, s_ready, m_valid = 0.
  - win0..win2 = 0; out_count = 0.
  - Sample counter, latency pipe and FIFO cleared.
  - Reset mid-frame discards all in-flight and buffered medians; no done pulse.
- Accept rule: a sample transfers when s_valid && s_ready; a median transfers when m_valid && m_ready.
- Window shift on each accepted sample, registered (new window visible the cycle after acceptance): win0<=win1, win1<=win2, win2<=s_data.
- FSM states:
  - IDLE: s_ready = 0. On start go to FILL, clear sample counter and out_count.
  - FILL: s_ready = 1. The first 2 accepted samples only shift the window and issue no median. After the 2nd acceptance go to RUN.
  - RUN: each accepted sample shifts the window and pushes a 1 into the MED_LAT-deep valid shift pipe.
    - s_ready = (fifo_count + inflight) < FIFO_DEPTH, where inflight = number of 1s in the valid pipe. This guarantees no FIFO overflow.
    - When the COUNT-th sample is accepted, go to DRAIN.
  - DRAIN: s_ready = 0. Wait until the valid pipe is empty, the FIFO is empty and the last median has been accepted. Then pulse done for 1 cycle and go to IDLE. busy drops the same cycle done is high.
- Median capture: when the valid pipe output is 1, med_in is written into the FIFO that cycle. Capture occurs MED_LAT cycles after the window register updated.
- FIFO:
  - Circular buffer, wrap-around pointers.
  - Simultaneous push and pop allowed when full or empty.
  - m_valid = !empty; m_data = head entry. No combinational path from med_in to m_data.
- out_count increments on each output transfer; after done it holds COUNT-2 until the next start.
- Samples presented while s_ready = 0 are not consumed.
- start during FILL, RUN or DRAIN is ignored.
- Total medians per frame is exactly COUNT-2, in sample order.

Test Plan:
- COUNT=5, MED_LAT=2, m_ready=1, samples 10,30,20,50,40 back-to-back after start -> medians 20,30,40 in order; done pulses once; out_count=3; busy low after done.
- Window timing: accept 7,3,9 -> win0/1/2 = 7/3/9 the cycle after the 3rd acceptance; med_in sampled exactly MED_LAT=2 cycles later.
- Backpressure: m_ready=0 for 20 cycles with FIFO_DEPTH=4 -> s_ready drops after 4 medians are buffered or in flight; no loss or duplication; releasing m_ready drains all 4 in order.
- Stall input: s_valid toggles every other cycle -> window shifts only on transfers; output sequence identical to back-to-back case.
- Reset mid-RUN after 3 medians issued -> all outputs 0 immediately (async); FIFO empty; no done. A new start runs a full frame with out_count=COUNT-2.
- start pulsed during RUN and during DRAIN -> ignored; a single done per frame; a second start in IDLE runs a second frame correctly.

Source files
------------

// File: rtl/median_window_feeder_if.sv
// Valid/ready word stream, used both for the incoming sample stream and
// for the outgoing median stream of the median window feeder.
interface median_window_feeder_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/median_window_feeder.sv
// Feeds a sliding 3-sample window to an external median filter and returns
// its results, COUNT-2 per frame, on a buffered ready/valid stream.
module median_window_feeder #(
    parameter int WIDTH      = 32,
    parameter int COUNT      = 8533,
    parameter int MED_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    median_window_feeder_if.slave  s,
    output logic [WIDTH-1:0]       win0,
    output logic [WIDTH-1:0]       win1,
    output logic [WIDTH-1:0]       win2,
    input  logic [WIDTH-1:0]       med_in,
    median_window_feeder_if.master m,
    output logic [31:0]            out_count
);

    localparam int SCW = $clog2(COUNT + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int IFW = $clog2(MED_LAT + 2);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [SCW-1:0]   samp_cnt;
    logic [MED_LAT:0] vpipe;
    logic [IFW-1:0]   inflight;
    logic [31:0]      occupancy;

    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [FCW-1:0]   fifo_count;

    logic             accept;
    logic             issue;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             pipe_empty;
    logic             clear_frame;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign accept     = s.valid && s.ready;
    assign issue      = accept && (state == RUN);
    assign fifo_empty = (fifo_count == '0);
    assign pipe_empty = (vpipe == '0);
    assign pop        = !fifo_empty && m.ready;
    // vpipe[0] marks the cycle a new window is presented; vpipe[MED_LAT]
    // marks the cycle its median is on med_in.
    assign push       = vpipe[MED_LAT];

    assign m.valid    = !fifo_empty;
    assign m.data     = fifo_mem[rd_ptr];

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= MED_LAT; i++) begin
            inflight = inflight + IFW'(vpipe[i]);
        end
    end

    // Buffered plus in-flight medians never exceed the FIFO, so capture can't overflow.
    assign occupancy = 32'(fifo_count) + 32'(inflight);
    assign s.ready   = (state == FILL) ||
                       ((state == RUN) && (occupancy < 32'(FIFO_DEPTH)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        done        = 1'b0;
        clear_frame = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = FILL;
                    clear_frame = 1'b1;
                end
            end
            FILL: begin
                if (accept && (samp_cnt == SCW'(1))) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && (samp_cnt == SCW'(COUNT - 1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty && fifo_empty) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE) && !done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt <= '0;
            win0     <= '0;
            win1     <= '0;
            win2     <= '0;
        end else begin
            if (clear_frame) begin
                samp_cnt <= '0;
            end else if (accept) begin
                samp_cnt <= samp_cnt + SCW'(1);
            end
            if (accept) begin
                win0 <= win1;
                win1 <= win2;
                win2 <= s.data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[MED_LAT-1:0], issue};
        end
    end

    // Storage is cleared too so m_data reads zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= med_in;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (clear_frame) begin
            out_count <= '0;
        end else if (pop) begin
            out_count <= out_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder: a behavioural 2-stage median filter closes the
// loop, and a scoreboard compares every emitted median against expectations.
module tb_median_window_feeder;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic        a_busy, a_done, b_busy, b_done;
    logic [31:0] a_win0, a_win1, a_win2, a_med, a_out_count;
    logic [31:0] b_win0, b_win1, b_win2, b_med, b_out_count;
    logic [31:0] fa1, fa2, fb1, fb2;

    median_window_feeder_if #(.WIDTH(32)) sa ();
    median_window_feeder_if #(.WIDTH(32)) ma ();
    median_window_feeder_if #(.WIDTH(32)) sb ();
    median_window_feeder_if #(.WIDTH(32)) mb ();

    median_window_feeder #(.WIDTH(32), .COUNT(5), .MED_LAT(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
        .s(sa), .win0(a_win0), .win1(a_win1), .win2(a_win2),
        .med_in(a_med), .m(ma), .out_count(a_out_count)
    );

    median_window_feeder #(.WIDTH(32), .COUNT(8), .MED_LAT(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
        .s(sb), .win0(b_win0), .win1(b_win1), .win2(b_win2),
        .med_in(b_med), .m(mb), .out_count(b_out_count)
    );

    typedef struct {
        logic [4:0][31:0] smp;
        logic [2:0][31:0] med;
        logic             stall;
        logic             poke;
    } vec_t;

    vec_t        tbl [5];
    vec_t        cur;
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          a_acc = 0, b_acc = 0;
    int          a_done_cnt = 0, b_done_cnt = 0;
    int          a_frames = 0;
    logic [31:0] b_h0 = 0, b_h1 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] med3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        if ((x >= y && x <= z) || (x <= y && x >= z)) return x;
        if ((y >= x && y <= z) || (y <= x && y >= z)) return y;
        return z;
    endfunction

    // External median filter with two register stages (MED_LAT = 2).
    always @(posedge clk) begin
        fa1 <= med3(a_win0, a_win1, a_win2);
        fa2 <= fa1;
        fb1 <= med3(b_win0, b_win1, b_win2);
        fb2 <= fb1;
    end
    assign a_med = fa2;
    assign b_med = fb2;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on sample acceptance, pop and compare on median transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (sa.valid && sa.ready) begin
                if (a_acc >= 2 && a_acc < 5) exp_a.push_back(cur.med[a_acc-2]);
                a_acc++;
            end
            if (ma.valid && ma.ready) begin
                if (exp_a.size() == 0) check_output("a_unexpected_median", ma.data, 32'hFFFF_FFFF);
                else check_output("a_median", ma.data, exp_a.pop_front());
            end
            if (a_done) a_done_cnt++;
            if (sb.valid && sb.ready) begin
                if (b_acc >= 2) exp_b.push_back(med3(b_h0, b_h1, sb.data));
                b_h0 = b_h1;
                b_h1 = sb.data;
                b_acc++;
            end
            if (mb.valid && mb.ready) begin
                if (exp_b.size() == 0) check_output("b_unexpected_median", mb.data, 32'hFFFF_FFFF);
                else check_output("b_median", mb.data, exp_b.pop_front());
            end
            if (b_done) b_done_cnt++;
        end
    end

    task automatic set_row(input int r, input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] s3, input logic [31:0] s4, input logic [31:0] m0,
                           input logic [31:0] m1, input logic [31:0] m2, input logic stall, input logic poke);
        tbl[r].smp[0] = s0; tbl[r].smp[1] = s1; tbl[r].smp[2] = s2;
        tbl[r].smp[3] = s3; tbl[r].smp[4] = s4;
        tbl[r].med[0] = m0; tbl[r].med[1] = m1; tbl[r].med[2] = m2;
        tbl[r].stall  = stall;
        tbl[r].poke   = poke;
    endtask

    task automatic apply_stimulus(input int r);
        bit acc;
        cur   = tbl[r];
        a_acc = 0;
        check_output("a_idle_s_ready", 32'(sa.ready), 0);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check_output("a_busy_after_start", 32'(a_busy), 1);
        for (int i = 0; i < 5; i++) begin
            if (cur.stall) begin
                sa.valid = 1'b0;
                sa.data  = 32'hBAD0_0000 + 32'(i);
                @(posedge clk); #1;
            end
            if (cur.poke && i == 3) start_a = 1'b1;
            sa.valid = 1'b1;
            sa.data  = cur.smp[i];
            acc = 0;
            for (int g = 0; g < 50 && !acc; g++) begin
                @(negedge clk);
                acc = sa.ready;
                @(posedge clk); #1;
            end
            start_a = 1'b0;
            check_output("a_accept_in_time", 32'(acc), 1);
            check_output("a_win2", a_win2, cur.smp[i]);
            if (i >= 1) check_output("a_win1", a_win1, cur.smp[i-1]);
            if (i >= 2) check_output("a_win0", a_win0, cur.smp[i-2]);
        end
        sa.valid = 1'b0;
        if (cur.poke) begin
            start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            check_output("a_busy_in_drain", 32'(a_busy), 1);
        end
    endtask

    task automatic wait_done(input bit which, input int exp_cnt);
        bit    seen = 0;
        string p = which ? "b" : "a";
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = which ? b_done : a_done;
        end
        check_output({p, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            check_output({p, "_busy_at_done"}, 32'(which ? b_busy : a_busy), 0);
            check_output({p, "_out_count_at_done"}, which ? b_out_count : a_out_count, 32'(exp_cnt));
        end
        @(posedge clk); #1;
        check_output({p, "_scoreboard_empty"}, 32'(which ? exp_b.size() : exp_a.size()), 0);
        check_output({p, "_out_count_hold"}, which ? b_out_count : a_out_count, 32'(exp_cnt));
    endtask

    initial begin
        logic [31:0] bvals [8];
        int          idx;
        int          done_before;
        bit          acc;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        sa.valid = 1'b0; sa.data = '0; ma.ready = 1'b1;
        sb.valid = 1'b0; sb.data = '0; mb.ready = 1'b0;

        set_row(0, 10, 30, 20, 50, 40, 20, 30, 40, 1'b0, 1'b0);
        set_row(1, 10, 30, 20, 50, 40, 20, 30, 40, 1'b1, 1'b0);
        set_row(2, 7, 3, 9, 1, 5, 7, 3, 5, 1'b0, 1'b0);
        set_row(3, 100, 100, 5, 5, 200, 100, 5, 5, 1'b0, 1'b1);
        set_row(4, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 32'hFFFF_FFFE,
                32'h8000_0000, 1, 32'h8000_0000, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", 32'(a_busy), 0);
        check_output("rst_done", 32'(a_done), 0);
        check_output("rst_s_ready", 32'(sa.ready), 0);
        check_output("rst_m_valid", 32'(ma.valid), 0);
        check_output("rst_win0", a_win0, 0);
        check_output("rst_win2", a_win2, 0);
        check_output("rst_out_count", a_out_count, 0);
        check_output("rst_b_s_ready", 32'(sb.ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 5; r++) begin
            apply_stimulus(r);
            wait_done(1'b0, 3);
            a_frames++;
            check_output("a_done_count", 32'(a_done_cnt), 32'(a_frames));
        end

        // Reset while three medians are held in the buffer.
        done_before = a_done_cnt;
        ma.ready = 1'b0;
        apply_stimulus(0);
        repeat (4) @(posedge clk);
        #1;
        check_output("hold_m_valid", 32'(ma.valid), 1);
        #2 rst = 1'b1;
        #1;
        check_output("mid_rst_busy", 32'(a_busy), 0);
        check_output("mid_rst_done", 32'(a_done), 0);
        check_output("mid_rst_s_ready", 32'(sa.ready), 0);
        check_output("mid_rst_m_valid", 32'(ma.valid), 0);
        check_output("mid_rst_m_data", ma.data, 0);
        check_output("mid_rst_win0", a_win0, 0);
        check_output("mid_rst_win1", a_win1, 0);
        check_output("mid_rst_win2", a_win2, 0);
        exp_a.delete();
        a_acc = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        ma.ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_output("no_done_after_reset", 32'(a_done_cnt), 32'(done_before));
        apply_stimulus(2);
        wait_done(1'b0, 3);
        check_output("a_done_after_reset_frame", 32'(a_done_cnt), 32'(done_before + 1));

        // Backpressure on the COUNT=8 instance: at most four medians may be outstanding.
        bvals = '{5, 1, 4, 2, 8, 3, 7, 6};
        b_acc = 0;
        mb.ready = 1'b0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        idx = 0;
        sb.valid = 1'b1;
        sb.data  = bvals[0];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = sb.valid && sb.ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 8) sb.data = bvals[idx];
                else sb.valid = 1'b0;
            end
        end
        check_output("bp_accepted", 32'(idx), 6);
        check_output("bp_s_ready_low", 32'(sb.ready), 0);
        check_output("bp_m_valid", 32'(mb.valid), 1);
        check_output("bp_out_count", b_out_count, 0);
        mb.ready = 1'b1;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            @(negedge clk);
            acc = sb.valid && sb.ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 8) sb.data = bvals[idx];
                else sb.valid = 1'b0;
            end
        end
        check_output("bp_all_accepted", 32'(idx), 8);
        sb.valid = 1'b0;
        wait_done(1'b1, 6);

        // Random valid and ready on both sides of the COUNT=8 instance.
        for (int i = 0; i < 8; i++) bvals[i] = $urandom;
        b_acc = 0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        idx = 0;
        for (int c = 0; c < 400 && idx < 8; c++) begin
            sb.valid = 1'($urandom_range(0, 1));
            sb.data  = bvals[idx];
            mb.ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = sb.valid && sb.ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        sb.valid = 1'b0;
        mb.ready = 1'b1;
        check_output("rand_all_accepted", 32'(idx), 8);
        wait_done(1'b1, 6);
        check_output("b_done_count", 32'(b_done_cnt), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
